// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter between
// NUM_REQ byte-stream requesters; an owner holds the transmitter until its last byte or a stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_dv;
    logic [7:0]         r_tx_byte;
    logic               r_last_q;
    logic               r_done_q;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_done_edge;
    logic               w_tx_free;
    logic               w_found;
    logic               w_hit;
    logic               w_owner_valid;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [7:0]         w_sel_byte;
    logic               w_sel_last;
    logic [NUM_REQ-1:0] w_ready;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        f_onehot      = {NUM_REQ{1'b0}};
        f_onehot[idx] = 1'b1;
    endfunction

    assign w_done_edge   = i_Tx_Done & ~r_done_q;
    assign w_tx_free     = ~i_Tx_Active & ~i_Tx_Done;
    assign w_owner_valid = |(i_Req_Valid & r_grant);
    assign w_sel_idx     = (r_state == S_HOLD) ? r_owner : w_win;

    // Round-robin search: first valid requester above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand  = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            w_hit   = ~w_found & i_Req_Valid[w_cand];
            w_win   = w_hit ? w_cand : w_win;
            w_found = w_found | w_hit;
        end
    end

    // Byte/last mux for whichever requester is being accepted this cycle.
    always_comb begin
        w_sel_byte = 8'h00;
        w_sel_last = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            w_sel_byte = w_sel_byte | ({8{IDX_W'(n) == w_sel_idx}} & i_Req_Byte[8*n +: 8]);
            w_sel_last = w_sel_last | ((IDX_W'(n) == w_sel_idx) & i_Req_Last[n]);
        end
    end

    // Accept strobe: the arbitration winner in idle, only the owner while a packet is locked.
    always_comb begin
        w_ready = {NUM_REQ{1'b0}};
        case (r_state)
            S_IDLE:  w_ready = (w_tx_free && w_found) ? f_onehot(w_win) : {NUM_REQ{1'b0}};
            S_HOLD:  w_ready = i_Req_Valid & r_grant;
            default: w_ready = {NUM_REQ{1'b0}};
        endcase
    end

    assign o_Req_Ready = i_Reset ? {NUM_REQ{1'b0}} : w_ready;
    assign o_Grant     = r_grant;
    assign o_Busy      = (r_state != S_IDLE);
    assign o_Tx_DV     = r_tx_dv;
    assign o_Tx_Byte   = r_tx_byte;

    // Arbiter FSM with registered transmitter strobe, byte, grant and stall counter.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= PTR_INIT;
            r_owner   <= {IDX_W{1'b0}};
            r_grant   <= {NUM_REQ{1'b0}};
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_last_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
        end else begin
            r_done_q <= i_Tx_Done;
            case (r_state)
                S_IDLE: begin
                    if (w_tx_free && w_found) begin
                        r_tx_byte <= w_sel_byte;
                        r_tx_dv   <= 1'b1;
                        r_grant   <= f_onehot(w_win);
                        r_owner   <= w_win;
                        r_last_q  <= w_sel_last;
                        r_state   <= S_SEND;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SEND: begin
                    r_tx_dv <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_edge && r_last_q) begin
                        r_ptr   <= r_owner;
                        r_grant <= {NUM_REQ{1'b0}};
                        r_state <= S_IDLE;
                    end else if (w_done_edge) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (w_owner_valid) begin
                        r_tx_byte <= w_sel_byte;
                        r_tx_dv   <= 1'b1;
                        r_last_q  <= w_sel_last;
                        r_cnt     <= {CNT_W{1'b0}};
                        r_state   <= S_SEND;
                    end else if (r_cnt == CNT_LAST) begin
                        // Owner stalled too long: abandon the packet and demote it.
                        r_ptr   <= r_owner;
                        r_grant <= {NUM_REQ{1'b0}};
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
